// File: rtl/disp_pkg.sv
// Shared defaults and round-robin helpers for the display source arbiter.
// Holds the display width, source count and a generic rr search function.
package disp_pkg;

  localparam int DISP_WIDTH = 16;
  localparam int DISP_N_SRC = 4;
  localparam int RR_MAXN    = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_res_t;

  // First set bit of req[n-1:0] searching ptr, ptr+1, ... wrapping at n.
  function automatic rr_res_t rr_first(
    input logic [RR_MAXN-1:0] req,
    input int                 n,
    input int                 ptr
  );
    rr_res_t r;
    r = '0;
    for (int i = RR_MAXN - 1; i >= 0; i--) begin
      if (i < n && i >= ptr && req[i]) begin
        r.found = 1'b1;
        r.idx   = 5'(i);
      end
    end
    if (!r.found) begin
      for (int i = RR_MAXN - 1; i >= 0; i--) begin
        if (i < n && req[i]) begin
          r.found = 1'b1;
          r.idx   = 5'(i);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/disp_src_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker using a double-width mask.
// Ports: req_i requests, ptr_i search start, found_o any hit, idx_o winner.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [2*N-1:0] dbl;

  // Lower copy masked below ptr, upper copy intact: the lowest set bit
  // of the doubled vector is the next requester at or after ptr.
  always_comb begin
    dbl = {req_i, req_i};
    for (int j = 0; j < N; j++) begin
      if (j < int'(ptr_i)) dbl[j] = 1'b0;
    end
    found_o = 1'b0;
    idx_o   = '0;
    for (int j = 2 * N - 1; j >= 0; j--) begin
      if (dbl[j]) begin
        found_o = 1'b1;
        idx_o   = (j >= N) ? IW'(j - N) : IW'(j);
      end
    end
  end

endmodule

// File: rtl/disp_src_arbiter.sv
// Round-robin arbiter sharing the 7-segment display between N value sources.
// Ports: clk/rst_n, i_req/i_data in; o_value, o_grant, o_idx, o_switch out.
module disp_src_arbiter
  import disp_pkg::*;
#(
  parameter int N_SRC        = DISP_N_SRC,
  parameter int WIDTH        = DISP_WIDTH,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_SRC-1:0]           i_req,
  input  logic [N_SRC*WIDTH-1:0]     i_data,
  output logic [WIDTH-1:0]           o_value,
  output logic [N_SRC-1:0]           o_grant,
  output logic [$clog2(N_SRC)-1:0]   o_idx,
  output logic                       o_switch
);

  localparam int IW = $clog2(N_SRC);
  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  localparam logic [CW-1:0] CNT_RELOAD = CW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N_SRC - 1);

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             switch_q, switch_d;

  logic [WIDTH-1:0] src [N_SRC];
  logic             pick_found;
  logic [IW-1:0]    pick_idx;

  for (genvar k = 0; k < N_SRC; k++) begin : g_src
    assign src[k] = i_data[k*WIDTH +: WIDTH];
  end

  rr_pick #(
    .N  (N_SRC),
    .IW (IW)
  ) u_pick (
    .req_i   (i_req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    grant_d  = grant_q;
    value_d  = value_q;
    switch_d = 1'b0;
    if (state_q == S_IDLE || cnt_q == '0) begin
      if (pick_found) begin
        state_d  = S_HOLD;
        cnt_d    = CNT_RELOAD;
        idx_d    = pick_idx;
        grant_d  = N_SRC'(1) << pick_idx;
        value_d  = src[pick_idx];
        ptr_d    = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
        // A reload onto the same source is not a new grant.
        switch_d = (state_q == S_IDLE) || (pick_idx != idx_q);
      end else begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
      // Freeze on the last sample once the owner stops requesting.
      if (i_req[idx_q]) value_d = src[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      idx_q    <= '0;
      grant_q  <= '0;
      value_q  <= '0;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      grant_q  <= grant_d;
      value_q  <= value_d;
      switch_q <= switch_d;
    end
  end

  assign o_value  = value_q;
  assign o_grant  = grant_q;
  assign o_idx    = idx_q;
  assign o_switch = switch_q;

endmodule
